// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types for the counter bank
// Purpose: mode, write-select and channel-state encodings plus a mode decode
// helper used by counter_bank and counter_channel.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    LD_COUNT = 2'd0,
    LD_LIMIT = 2'd1,
    LD_MODE  = 2'd2,
    LD_NONE  = 2'd3
  } wr_sel_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } ch_state_e;

  // Encoding 3 has no mode of its own; it is stored as WRAP.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    decode_mode = MODE_SAT;
      2'd2:    decode_mode = MODE_ONESHOT;
      default: decode_mode = MODE_WRAP;
    endcase
  endfunction

endpackage

// File: rtl/counter_channel.sv
// rtl/counter_channel.sv - one up/down counter channel with limit and mode
// Purpose: holds count/limit/mode/run-state for a single channel and performs
// the step and terminal-count logic.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   en_i, up_down_i        step enable, direction (1 = up)
//   ld_count_i/limit/mode  decoded write strobes for this channel (one-hot)
//   wr_data_i              write data (mode uses [1:0])
//   count_o                current count
//   tc_o                   registered terminal-count pulse
//   at_term_o              combinational terminal-condition level
//   done_o                 ONESHOT finished
module counter_channel
  import counter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             up_down_i,
  input  logic             ld_count_i,
  input  logic             ld_limit_i,
  input  logic             ld_mode_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             at_term_o,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  mode_e            mode_q, mode_d;
  ch_state_e        state_q, state_d;
  logic             tc_q, tc_d;

  logic wr_any;
  logic step;
  logic term;

  // Up uses >= so a limit lowered beneath the count is still terminal.
  assign term   = up_down_i ? (count_q >= limit_q) : (count_q == '0);
  assign wr_any = ld_count_i | ld_limit_i | ld_mode_i;
  assign step   = en_i & (state_q == ST_RUN) & ~wr_any;

  always_comb begin
    count_d = count_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    state_d = state_q;
    tc_d    = step & term;

    if (ld_count_i) begin
      count_d = wr_data_i;
      state_d = ST_RUN;
    end else if (ld_limit_i) begin
      limit_d = wr_data_i;
    end else if (ld_mode_i) begin
      mode_d  = decode_mode(wr_data_i[1:0]);
      state_d = ST_RUN;
    end else if (step) begin
      if (!term) begin
        count_d = up_down_i ? count_q + 1'b1 : count_q - 1'b1;
      end else begin
        case (mode_q)
          MODE_WRAP:    count_d = up_down_i ? '0 : limit_q;
          MODE_SAT:     count_d = up_down_i ? limit_q : '0;
          MODE_ONESHOT: state_d = ST_DONE;
          default:      count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      limit_q <= '1;
      mode_q  <= MODE_WRAP;
      state_q <= ST_RUN;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      state_q <= state_d;
      tc_q    <= tc_d;
    end
  end

  assign count_o   = count_q;
  assign tc_o      = tc_q;
  assign at_term_o = term;
  assign done_o    = (state_q == ST_DONE);

endmodule

// File: rtl/counter_bank.sv
// rtl/counter_bank.sv - bank of N_CH independent up/down counters
// Purpose: decodes the shared write port, instantiates one counter_channel per
// channel, packs outputs and holds the sticky IRQ status.
// Optional feature macro: COUNTER_BANK_IRQ_EN (IRQ status/irq_o logic).
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   en_i, up_down_i  per-channel step enable and direction
//   wr_en_i, wr_ch_i, wr_sel_i, wr_data_i  shared write port
//   count_o          packed counts, ch i at [i*WIDTH +: WIDTH]
//   tc_o, at_term_o, done_o  per-channel status
//   irq_clr_i        W1C for irq_status_o
//   irq_status_o     sticky terminal flags, irq_o = |irq_status_o
module counter_bank
  import counter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_CH  = 4,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_CH-1:0]       en_i,
  input  logic [N_CH-1:0]       up_down_i,
  input  logic                  wr_en_i,
  input  logic [CH_W-1:0]       wr_ch_i,
  input  logic [1:0]            wr_sel_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  output logic [N_CH*WIDTH-1:0] count_o,
  output logic [N_CH-1:0]       tc_o,
  output logic [N_CH-1:0]       at_term_o,
  output logic [N_CH-1:0]       done_o,
  input  logic [N_CH-1:0]       irq_clr_i,
  output logic [N_CH-1:0]       irq_status_o,
  output logic                  irq_o
);

  logic ld_count, ld_limit, ld_mode;

  assign ld_count = wr_en_i & (wr_sel_i == LD_COUNT);
  assign ld_limit = wr_en_i & (wr_sel_i == LD_LIMIT);
  assign ld_mode  = wr_en_i & (wr_sel_i == LD_MODE);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    // Exact index match: an out-of-range wr_ch_i selects no channel.
    logic hit;
    assign hit = (wr_ch_i == CH_W'(i));

    counter_channel #(.WIDTH(WIDTH)) u_ch (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .en_i       (en_i[i]),
      .up_down_i  (up_down_i[i]),
      .ld_count_i (ld_count & hit),
      .ld_limit_i (ld_limit & hit),
      .ld_mode_i  (ld_mode & hit),
      .wr_data_i  (wr_data_i),
      .count_o    (count_o[i*WIDTH +: WIDTH]),
      .tc_o       (tc_o[i]),
      .at_term_o  (at_term_o[i]),
      .done_o     (done_o[i])
    );
  end

`ifdef COUNTER_BANK_IRQ_EN
  logic [N_CH-1:0] irq_status_q, irq_status_d;

  // Set wins over a same-cycle clear.
  assign irq_status_d = (irq_status_q & ~irq_clr_i) | tc_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_status_q <= '0;
    end else begin
      irq_status_q <= irq_status_d;
    end
  end

  assign irq_status_o = irq_status_q;
  assign irq_o        = |irq_status_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = |irq_clr_i;
  assign irq_status_o   = '0;
  assign irq_o          = 1'b0;
`endif

endmodule

// File: tb/tb_counter_bank.sv
// tb/tb_counter_bank.sv - directed self-checking bench for counter_bank
module tb_counter_bank;

  localparam int WIDTH = 8;
  localparam int N_CH  = 4;

  logic                  clk;
  logic                  rst;
  logic [N_CH-1:0]       en;
  logic [N_CH-1:0]       up_down;
  logic                  wr_en;
  logic [1:0]            wr_ch;
  logic [1:0]            wr_sel;
  logic [WIDTH-1:0]      wr_data;
  logic [N_CH*WIDTH-1:0] count;
  logic [N_CH-1:0]       tc;
  logic [N_CH-1:0]       at_term;
  logic [N_CH-1:0]       done;
  logic [N_CH-1:0]       irq_clr;
  logic [N_CH-1:0]       irq_status;
  logic                  irq;

  int n_tests = 0;
  int n_fail  = 0;

  counter_bank #(.WIDTH(WIDTH), .N_CH(N_CH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .up_down_i    (up_down),
    .wr_en_i      (wr_en),
    .wr_ch_i      (wr_ch),
    .wr_sel_i     (wr_sel),
    .wr_data_i    (wr_data),
    .count_o      (count),
    .tc_o         (tc),
    .at_term_o    (at_term),
    .done_o       (done),
    .irq_clr_i    (irq_clr),
    .irq_status_o (irq_status),
    .irq_o        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] cnt(input int ch);
    cnt = count[ch*WIDTH +: WIDTH];
  endfunction

  // Inputs change 1 time unit after the rising edge; checks happen there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int sel, input int data);
    wr_en   = 1'b1;
    wr_ch   = 2'(ch);
    wr_sel  = 2'(sel);
    wr_data = 8'(data);
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    int exp_seq[7];
    exp_seq = '{1, 2, 3, 4, 5, 0, 1};

    rst = 1'b1; en = '0; up_down = '0; wr_en = 1'b0; wr_ch = '0;
    wr_sel = '0; wr_data = '0; irq_clr = '0;
    tick(); tick();
    rst = 1'b0;

    check("rst_count", count, 0);
    check("rst_tc", tc, 0);
    check("rst_done", done, 0);
    check("rst_irq_status", irq_status, 0);
    check("rst_irq", irq, 0);
    check("rst_at_term_down", at_term, 4'b1111);
    up_down = 4'b1111;
    #1;
    check("rst_at_term_up", at_term, 4'b0000);

    // ch0: WRAP up, limit 5
    wr(0, 1, 5);
    en[0] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      check($sformatf("ch0_count_%0d", k), cnt(0), exp_seq[k]);
      check($sformatf("ch0_tc_%0d", k), tc[0], (k == 5) ? 1 : 0);
    end
    en[0] = 1'b0;

    // ch1: SAT down from 2, limit 3
    wr(1, 2, 1);
    wr(1, 1, 3);
    wr(1, 0, 2);
    up_down[1] = 1'b0;
    en[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("ch1_count_%0d", k), cnt(1), (k == 0) ? 1 : 0);
      check($sformatf("ch1_tc_%0d", k), tc[1], (k >= 2) ? 1 : 0);
    end
    en[1] = 1'b0;

    // ch2: ONESHOT up, limit 2
    wr(2, 2, 2);
    wr(2, 1, 2);
    en[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("ch2_count_%0d", k), cnt(2), (k == 0) ? 1 : 2);
      check($sformatf("ch2_tc_%0d", k), tc[2], (k == 2) ? 1 : 0);
      check($sformatf("ch2_done_%0d", k), done[2], (k >= 2) ? 1 : 0);
    end
    check("ch2_at_term_done", at_term[2], 1);
    wr(2, 0, 0);
    check("ch2_reload_count", cnt(2), 0);
    check("ch2_reload_done", done[2], 0);
    check("ch2_reload_tc", tc[2], 0);
    tick();
    check("ch2_resume", cnt(2), 1);
    en[2] = 1'b0;

    // ch3: write beats a same-cycle step; lowered limit is terminal
    wr(3, 0, 200);
    en[3] = 1'b1;
    wr(3, 0, 10);
    check("ch3_wr_beats_step", cnt(3), 10);
    check("ch3_wr_no_tc", tc[3], 0);
    wr(3, 1, 4);
    check("ch3_ld_limit_keeps_count", cnt(3), 10);
    check("ch3_at_term_lowered", at_term[3], 1);
    tick();
    check("ch3_wrap_count", cnt(3), 0);
    check("ch3_wrap_tc", tc[3], 1);
    en[3] = 1'b0;
    wr(3, 3, 99);
    check("ch3_sel3_ignored", cnt(3), 0);
    wr(3, 2, 3);
    wr(3, 0, 4);
    en[3] = 1'b1;
    tick();
    check("ch3_mode3_is_wrap", cnt(3), 0);
    en[3] = 1'b0;

    // IRQ: clear everything, then set vs same-cycle clear on ch0
    tick();
    irq_clr = 4'b1111;
    tick();
    irq_clr = '0;
    check("irq_cleared", irq_status, 0);
    wr(0, 0, 5);
    en[0] = 1'b1;
    tick();
    en[0] = 1'b0;
    check("irq_tc0", tc[0], 1);
    irq_clr[0] = 1'b1;
    tick();
`ifdef COUNTER_BANK_IRQ_EN
    check("irq_set_wins", irq_status[0], 1);
    check("irq_o_set", irq, 1);
`else
    check("irq_tied_status", irq_status, 0);
    check("irq_tied_o", irq, 0);
`endif
    tick();
    irq_clr[0] = 1'b0;
    check("irq_clr_status", irq_status, 0);
    check("irq_clr_o", irq, 0);

    // Reset while ch2 is DONE, with a step and a write pending
    wr(2, 0, 2);
    en[2] = 1'b1;
    tick();
    check("ch2_done_again", done[2], 1);
    rst = 1'b1;
    en = 4'b1111;
    wr(1, 0, 77);
    rst = 1'b0;
    en = '0;
    check("rst2_count", count, 0);
    check("rst2_tc", tc, 0);
    check("rst2_done", done, 0);
    check("rst2_irq_status", irq_status, 0);
    check("rst2_irq", irq, 0);
    up_down = 4'b1111;
    #1;
    check("rst2_limit_max", at_term, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
